condicionador_jogada: RTL and testbench

//  Upstream stage of the game datapath. Conditions the raw button inputs before

---
 rtl/condicionador_jogada.sv | 122 ++++++++++++
 tb/tb_condicionador_jogada.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/condicionador_jogada.sv
// Button conditioner: 2-FF synchronizer, press/release debounce and one-hot
// validation, producing a held move code plus one-cycle accept/multiple strobes.
module condicionador_jogada #(
    parameter int N_BOTOES        = 4,
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                habilita,
    output logic                jogada_valida,
    output logic [N_BOTOES-1:0] jogada,
    output logic                jogada_multipla,
    output logic [3:0]          db_estado
);

    localparam int CNT_W = $clog2(DEBOUNCE_CICLOS);
    localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CICLOS - 1);
    localparam logic [CNT_W-1:0] CNT_UM  = CNT_W'(1);

    localparam logic [1:0] ESPERA       = 2'd0;
    localparam logic [1:0] FILTRA_PRESS = 2'd1;
    localparam logic [1:0] PRESSIONADO  = 2'd2;
    localparam logic [1:0] FILTRA_SOLTA = 2'd3;

    logic [N_BOTOES-1:0] sinc1_q, sinc2_q;
    logic [1:0]          estado_q, estado_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_BOTOES-1:0] amostra_q, amostra_d;
    logic [N_BOTOES-1:0] jogada_q, jogada_d;
    logic                valida_q, valida_d;
    logic                multipla_q, multipla_d;

    function automatic logic eh_onehot(input logic [N_BOTOES-1:0] v);
        return (v != '0) && ((v & (v - N_BOTOES'(1))) == '0);
    endfunction

    always_comb begin
        estado_d   = estado_q;
        cnt_d      = cnt_q;
        amostra_d  = amostra_q;
        jogada_d   = jogada_q;
        valida_d   = 1'b0;
        multipla_d = 1'b0;
        case (estado_q)
            ESPERA: begin
                if (habilita && (sinc2_q != '0)) begin
                    amostra_d = sinc2_q;
                    estado_d  = FILTRA_PRESS;
                    cnt_d     = '0;
                end
            end
            FILTRA_PRESS: begin
                // Any change of the sampled pattern or loss of enable aborts silently.
                if (!habilita || (sinc2_q != amostra_q)) begin
                    estado_d = ESPERA;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_FIM) begin
                    estado_d = PRESSIONADO;
                    cnt_d    = '0;
                    if (eh_onehot(amostra_q)) begin
                        jogada_d = amostra_q;
                        valida_d = 1'b1;
                    end else begin
                        multipla_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_UM;
                end
            end
            PRESSIONADO: begin
                if (sinc2_q == '0) begin
                    estado_d = FILTRA_SOLTA;
                    cnt_d    = '0;
                end
            end
            FILTRA_SOLTA: begin
                if (sinc2_q != '0) begin
                    estado_d = PRESSIONADO;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_FIM) begin
                    estado_d = ESPERA;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_UM;
                end
            end
            default: begin
                estado_d = ESPERA;
                cnt_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sinc1_q    <= '0;
            sinc2_q    <= '0;
            estado_q   <= ESPERA;
            cnt_q      <= '0;
            amostra_q  <= '0;
            jogada_q   <= '0;
            valida_q   <= 1'b0;
            multipla_q <= 1'b0;
        end else begin
            sinc1_q    <= botoes;
            sinc2_q    <= sinc1_q;
            estado_q   <= estado_d;
            cnt_q      <= cnt_d;
            amostra_q  <= amostra_d;
            jogada_q   <= jogada_d;
            valida_q   <= valida_d;
            multipla_q <= multipla_d;
        end
    end

    assign jogada_valida   = valida_q;
    assign jogada_multipla = multipla_q;
    assign jogada          = jogada_q;
    assign db_estado       = {2'b00, estado_q};

endmodule

// File: tb/tb_condicionador_jogada.sv
// Bench for condicionador_jogada with DEBOUNCE_CICLOS=4: strobes are matched
// against a queue of expected events filled when each press is driven.
module tb_condicionador_jogada;

    localparam int NB = 4;
    localparam int D  = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [NB-1:0] botoes;
    logic          habilita;
    logic          jogada_valida;
    logic [NB-1:0] jogada;
    logic          jogada_multipla;
    logic [3:0]    db_estado;

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic          mult;
        logic [NB-1:0] code;
        int            at;
    } esperado_t;

    esperado_t sb[$];

    condicionador_jogada #(.N_BOTOES(NB), .DEBOUNCE_CICLOS(D)) dut (
        .clock(clock),
        .reset(reset),
        .botoes(botoes),
        .habilita(habilita),
        .jogada_valida(jogada_valida),
        .jogada(jogada),
        .jogada_multipla(jogada_multipla),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Every strobe must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (jogada_valida || jogada_multipla) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_strobe cycle %0d: valida=%b multipla=%b jogada=%b, required no strobe",
                         cyc, jogada_valida, jogada_multipla, jogada);
            end else begin
                esperado_t e;
                e = sb.pop_front();
                if (jogada_valida !== !e.mult || jogada_multipla !== e.mult || jogada !== e.code ||
                    (e.at >= 0 && cyc != e.at)) begin
                    n_errors++;
                    $display("FAIL strobe cycle %0d: valida=%b multipla=%b jogada=%b, required multipla=%b jogada=%b cycle %0d",
                             cyc, jogada_valida, jogada_multipla, jogada, e.mult, e.code, e.at);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic test_reset;
        reset = 1'b1; botoes = '0; habilita = 1'b0;
        tick(2);
        n_checks++;
        if (jogada_valida !== 1'b0) begin n_errors++; $display("FAIL reset_valida got %b want 0", jogada_valida); end
        n_checks++;
        if (jogada_multipla !== 1'b0) begin n_errors++; $display("FAIL reset_multipla got %b want 0", jogada_multipla); end
        n_checks++;
        if (jogada !== 4'b0000) begin n_errors++; $display("FAIL reset_jogada got %b want 0000", jogada); end
        n_checks++;
        if (db_estado !== 4'd0) begin n_errors++; $display("FAIL reset_estado got %0d want 0", db_estado); end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_press_valid;
        habilita = 1'b1;
        botoes = 4'b0010;
        sb.push_back('{mult: 1'b0, code: 4'b0010, at: cyc + D + 3});
        tick(D + 2);
        n_checks++;
        if (jogada !== 4'b0000 || db_estado !== 4'd1) begin
            n_errors++; $display("FAIL press_before got jogada=%b estado=%0d want 0000/1", jogada, db_estado);
        end
        tick(3);
        n_checks++;
        if (jogada !== 4'b0010 || db_estado !== 4'd2) begin
            n_errors++; $display("FAIL press_held got jogada=%b estado=%0d want 0010/2", jogada, db_estado);
        end
        botoes = '0;
        tick(D + 5);
        n_checks++;
        if (jogada !== 4'b0010 || db_estado !== 4'd0) begin
            n_errors++; $display("FAIL press_released got jogada=%b estado=%0d want 0010/0", jogada, db_estado);
        end
        n_checks++;
        if (sb.size() != 0) begin n_errors++; $display("FAIL press_pending got %0d want 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_glitch_bounce;
        botoes = 4'b0100;
        tick(2);
        botoes = '0;
        tick(1);
        n_checks++;
        if (db_estado !== 4'd1) begin n_errors++; $display("FAIL glitch_filtra got %0d want 1", db_estado); end
        tick(2);
        n_checks++;
        if (db_estado !== 4'd0) begin n_errors++; $display("FAIL glitch_abort got %0d want 0", db_estado); end
        for (int i = 0; i < 3; i++) begin
            botoes = 4'b1000; tick(2);
            botoes = 4'b0000; tick(2);
        end
        botoes = 4'b1000;
        sb.push_back('{mult: 1'b0, code: 4'b1000, at: cyc + D + 3});
        tick(D + 5);
        n_checks++;
        if (jogada !== 4'b1000) begin n_errors++; $display("FAIL bounce_jogada got %b want 1000", jogada); end
        botoes = '0;
        tick(D + 5);
        n_checks++;
        if (sb.size() != 0) begin n_errors++; $display("FAIL bounce_pending got %0d want 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_multiple;
        botoes = 4'b0011;
        sb.push_back('{mult: 1'b1, code: 4'b1000, at: cyc + D + 3});
        tick(D + 5);
        n_checks++;
        if (jogada !== 4'b1000 || db_estado !== 4'd2) begin
            n_errors++; $display("FAIL multiple_held got jogada=%b estado=%0d want 1000/2", jogada, db_estado);
        end
        botoes = '0;
        tick(D + 5);
        n_checks++;
        if (sb.size() != 0) begin n_errors++; $display("FAIL multiple_pending got %0d want 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_hold_release;
        int exp_db[9] = '{2, 2, 3, 2, 3, 3, 3, 3, 0};
        botoes = 4'b0001;
        sb.push_back('{mult: 1'b0, code: 4'b0001, at: cyc + D + 3});
        tick(50);
        n_checks++;
        if (db_estado !== 4'd2) begin n_errors++; $display("FAIL hold_estado got %0d want 2", db_estado); end
        botoes = '0;
        for (int i = 0; i < 9; i++) begin
            tick(1);
            n_checks++;
            if (db_estado !== 4'(exp_db[i])) begin
                n_errors++; $display("FAIL release_seq[%0d] got %0d want %0d", i, db_estado, exp_db[i]);
            end
            if (i == 0) botoes = 4'b0001;
            if (i == 1) botoes = 4'b0000;
        end
        botoes = 4'b0001;
        sb.push_back('{mult: 1'b0, code: 4'b0001, at: cyc + D + 3});
        tick(D + 5);
        n_checks++;
        if (db_estado !== 4'd2) begin n_errors++; $display("FAIL repress_estado got %0d want 2", db_estado); end
        botoes = '0;
        tick(D + 5);
        n_checks++;
        if (sb.size() != 0) begin n_errors++; $display("FAIL hold_pending got %0d want 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_habilita;
        habilita = 1'b0;
        botoes = 4'b0100;
        tick(10);
        n_checks++;
        if (db_estado !== 4'd0) begin n_errors++; $display("FAIL disabled_estado got %0d want 0", db_estado); end
        habilita = 1'b1;
        sb.push_back('{mult: 1'b0, code: 4'b0100, at: -1});
        tick(1);
        n_checks++;
        if (db_estado !== 4'd1) begin n_errors++; $display("FAIL enable_filtra got %0d want 1", db_estado); end
        tick(D + 3);
        n_checks++;
        if (jogada !== 4'b0100) begin n_errors++; $display("FAIL enable_jogada got %b want 0100", jogada); end
        botoes = '0;
        tick(D + 5);
        botoes = 4'b0010;
        tick(4);
        n_checks++;
        if (db_estado !== 4'd1) begin n_errors++; $display("FAIL drop_filtra got %0d want 1", db_estado); end
        habilita = 1'b0;
        tick(1);
        n_checks++;
        if (db_estado !== 4'd0) begin n_errors++; $display("FAIL drop_abort got %0d want 0", db_estado); end
        tick(5);
        n_checks++;
        if (db_estado !== 4'd0 || jogada !== 4'b0100) begin
            n_errors++; $display("FAIL drop_idle got jogada=%b estado=%0d want 0100/0", jogada, db_estado);
        end
        botoes = '0;
        tick(5);
        habilita = 1'b1;
        tick(2);
        n_checks++;
        if (sb.size() != 0) begin n_errors++; $display("FAIL habilita_pending got %0d want 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_reset_mid;
        botoes = 4'b0001;
        sb.push_back('{mult: 1'b0, code: 4'b0001, at: cyc + D + 3});
        tick(D + 5);
        n_checks++;
        if (db_estado !== 4'd2) begin n_errors++; $display("FAIL midreset_pre got %0d want 2", db_estado); end
        reset = 1'b1;
        tick(1);
        n_checks++;
        if (jogada_valida !== 1'b0 || jogada_multipla !== 1'b0 || jogada !== 4'b0000 || db_estado !== 4'd0) begin
            n_errors++;
            $display("FAIL midreset_outputs got valida=%b multipla=%b jogada=%b estado=%0d want 0/0/0000/0",
                     jogada_valida, jogada_multipla, jogada, db_estado);
        end
        reset = 1'b0;
        sb.push_back('{mult: 1'b0, code: 4'b0001, at: cyc + D + 3});
        tick(D + 5);
        n_checks++;
        if (jogada !== 4'b0001 || db_estado !== 4'd2) begin
            n_errors++; $display("FAIL midreset_repress got jogada=%b estado=%0d want 0001/2", jogada, db_estado);
        end
        botoes = '0;
        tick(D + 5);
        n_checks++;
        if (sb.size() != 0) begin n_errors++; $display("FAIL midreset_pending got %0d want 0", sb.size()); sb.delete(); end
    endtask

    initial begin
        reset = 1'b1;
        botoes = '0;
        habilita = 1'b0;
        test_reset();
        test_press_valid();
        test_glitch_bounce();
        test_multiple();
        test_hold_release();
        test_habilita();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
